// File: rtl/uart_pkg.sv
// Shared constants for the UART receive path: parity selectors and the
// receiver FSM state encoding.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = S_IDLE,
        ST_START  = S_START,
        ST_DATA   = S_DATA,
        ST_PARITY = S_PARITY,
        ST_STOP   = S_STOP
    } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line; resets to the idle
// (high) level so a reset never looks like a start bit.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic [1:0] sync_q;
    logic [1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[0], din};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign dout = sync_q[1];

endmodule

// File: rtl/uart_rx_engine.sv
// Oversampling UART receiver: mid-bit start validation, configurable frame
// format, per-frame parity/stop flags and a valid/ready output register.
module uart_rx_engine
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_MODE  = 1,
    parameter int STOP_BITS    = 1
) (
    input  logic                  RX_CLK,
    input  logic                  RX_RST,
    input  logic                  RX_IN,
    input  logic                  RX_READY,
    output logic [DATA_WIDTH-1:0] RX_DATA,
    output logic                  RX_VALID,
    output logic                  PARITY_BIT_ERROR,
    output logic                  STOP_BIT_ERROR,
    output logic                  OVERRUN_ERROR,
    output logic                  RX_BUSY
);

    localparam int CNT_W  = $clog2(CLKS_PER_BIT);
    localparam int DCNT_W = $clog2(DATA_WIDTH + 1);

    localparam logic [CNT_W-1:0]  SAMPLE_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]  WRAP_CNT   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [DCNT_W-1:0] DATA_LAST  = DCNT_W'(DATA_WIDTH - 1);
    localparam logic              STOP_LAST  = (STOP_BITS == 2);
    localparam logic              ODD_SEL    = (PARITY_MODE == PARITY_ODD);
    localparam logic              HAS_PARITY = (PARITY_MODE != PARITY_NONE);

    logic rx_s;

    uart_rx_sync u_sync (
        .clk  (RX_CLK),
        .rst  (RX_RST),
        .din  (RX_IN),
        .dout (rx_s)
    );

    rx_state_e             state_q,     state_d;
    logic [CNT_W-1:0]      bit_cnt_q,   bit_cnt_d;
    logic [DCNT_W-1:0]     data_cnt_q,  data_cnt_d;
    logic                  stop_cnt_q,  stop_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q,     shift_d;
    logic                  par_err_q,   par_err_d;
    logic                  stop_err_q,  stop_err_d;
    logic                  armed_q,     armed_d;
    logic                  done_q,      done_d;
    logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;
    logic                  valid_q,     valid_d;
    logic                  out_perr_q,  out_perr_d;
    logic                  out_serr_q,  out_serr_d;
    logic                  ovr_q,       ovr_d;

    logic sample_mid;
    logic wrap;

    assign sample_mid = (bit_cnt_q == SAMPLE_CNT);
    assign wrap       = (bit_cnt_q == WRAP_CNT);

    // After the start bit is confirmed at mid-bit the counter restarts, so
    // every later wrap lands in the middle of the following bit.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        data_cnt_d = data_cnt_q;
        stop_cnt_d = stop_cnt_q;
        shift_d    = shift_q;
        par_err_d  = par_err_q;
        stop_err_d = stop_err_q;
        armed_d    = armed_q;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                bit_cnt_d = '0;
                if (rx_s) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (sample_mid) begin
                    bit_cnt_d = '0;
                    if (rx_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d    = ST_DATA;
                        data_cnt_d = '0;
                        par_err_d  = 1'b0;
                        stop_err_d = 1'b0;
                    end
                end
            end
            ST_DATA: begin
                bit_cnt_d = wrap ? '0 : bit_cnt_q + 1'b1;
                if (wrap) begin
                    shift_d    = {rx_s, shift_q[DATA_WIDTH-1:1]};
                    data_cnt_d = data_cnt_q + 1'b1;
                    if (data_cnt_q == DATA_LAST) begin
                        state_d    = HAS_PARITY ? ST_PARITY : ST_STOP;
                        stop_cnt_d = 1'b0;
                    end
                end
            end
            ST_PARITY: begin
                bit_cnt_d = wrap ? '0 : bit_cnt_q + 1'b1;
                if (wrap) begin
                    par_err_d  = ((^shift_q) ^ rx_s) != ODD_SEL;
                    state_d    = ST_STOP;
                    stop_cnt_d = 1'b0;
                end
            end
            ST_STOP: begin
                bit_cnt_d = wrap ? '0 : bit_cnt_q + 1'b1;
                if (wrap) begin
                    stop_err_d = stop_err_q | ~rx_s;
                    if (stop_cnt_q == STOP_LAST) begin
                        // A low final stop (break) must see the line high
                        // again before another start is accepted.
                        state_d   = ST_IDLE;
                        done_d    = 1'b1;
                        armed_d   = rx_s;
                        bit_cnt_d = '0;
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        out_data_d = out_data_q;
        valid_d    = valid_q;
        out_perr_d = out_perr_q;
        out_serr_d = out_serr_q;
        ovr_d      = ovr_q;

        if (done_q) begin
            if (!valid_q || RX_READY) begin
                out_data_d = shift_q;
                out_perr_d = par_err_q;
                out_serr_d = stop_err_q;
                valid_d    = 1'b1;
                if (valid_q) begin
                    ovr_d = 1'b0;
                end
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && RX_READY) begin
            valid_d    = 1'b0;
            out_perr_d = 1'b0;
            out_serr_d = 1'b0;
            ovr_d      = 1'b0;
        end
    end

    always_ff @(posedge RX_CLK or posedge RX_RST) begin
        if (RX_RST) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            data_cnt_q <= '0;
            stop_cnt_q <= 1'b0;
            shift_q    <= '0;
            par_err_q  <= 1'b0;
            stop_err_q <= 1'b0;
            armed_q    <= 1'b0;
            done_q     <= 1'b0;
            out_data_q <= '0;
            valid_q    <= 1'b0;
            out_perr_q <= 1'b0;
            out_serr_q <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            data_cnt_q <= data_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            shift_q    <= shift_d;
            par_err_q  <= par_err_d;
            stop_err_q <= stop_err_d;
            armed_q    <= armed_d;
            done_q     <= done_d;
            out_data_q <= out_data_d;
            valid_q    <= valid_d;
            out_perr_q <= out_perr_d;
            out_serr_q <= out_serr_d;
            ovr_q      <= ovr_d;
        end
    end

    assign RX_DATA          = out_data_q;
    assign RX_VALID         = valid_q;
    assign PARITY_BIT_ERROR = out_perr_q;
    assign STOP_BIT_ERROR   = out_serr_q;
    assign OVERRUN_ERROR    = ovr_q;
    assign RX_BUSY          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_engine.sv
// Directed plus randomized bench for uart_rx_engine: three instances cover
// even parity / 1 stop, odd parity, and 2 stop bits.
module tb_uart_rx_engine;

    localparam int CPB = 16;

    logic       clk;
    logic       rst;
    logic       ready;
    logic       rx_line  [3];
    logic [7:0] data_o   [3];
    logic       valid_o  [3];
    logic       perr_o   [3];
    logic       serr_o   [3];
    logic       ovr_o    [3];
    logic       busy_o   [3];

    int checks = 0;
    int errors = 0;
    int exp_cnt [3];
    int pulses0 = 0;
    logic prev_valid0 = 1'b0;

    logic [9:0] q0[$];
    logic [9:0] q1[$];
    logic [9:0] q2[$];

    uart_rx_engine #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_MODE(1), .STOP_BITS(1)) dut0 (
        .RX_CLK(clk), .RX_RST(rst), .RX_IN(rx_line[0]), .RX_READY(ready),
        .RX_DATA(data_o[0]), .RX_VALID(valid_o[0]), .PARITY_BIT_ERROR(perr_o[0]),
        .STOP_BIT_ERROR(serr_o[0]), .OVERRUN_ERROR(ovr_o[0]), .RX_BUSY(busy_o[0]));

    uart_rx_engine #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_MODE(2), .STOP_BITS(1)) dut1 (
        .RX_CLK(clk), .RX_RST(rst), .RX_IN(rx_line[1]), .RX_READY(ready),
        .RX_DATA(data_o[1]), .RX_VALID(valid_o[1]), .PARITY_BIT_ERROR(perr_o[1]),
        .STOP_BIT_ERROR(serr_o[1]), .OVERRUN_ERROR(ovr_o[1]), .RX_BUSY(busy_o[1]));

    uart_rx_engine #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_MODE(1), .STOP_BITS(2)) dut2 (
        .RX_CLK(clk), .RX_RST(rst), .RX_IN(rx_line[2]), .RX_READY(ready),
        .RX_DATA(data_o[2]), .RX_VALID(valid_o[2]), .PARITY_BIT_ERROR(perr_o[2]),
        .STOP_BIT_ERROR(serr_o[2]), .OVERRUN_ERROR(ovr_o[2]), .RX_BUSY(busy_o[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every accepted word as {stop_err, parity_err, data}.
    always @(negedge clk) begin
        if (valid_o[0] && ready) q0.push_back({serr_o[0], perr_o[0], data_o[0]});
        if (valid_o[1] && ready) q1.push_back({serr_o[1], perr_o[1], data_o[1]});
        if (valid_o[2] && ready) q2.push_back({serr_o[2], perr_o[2], data_o[2]});
        if (valid_o[0] && !prev_valid0) pulses0++;
        prev_valid0 = valid_o[0];
    end

    function automatic int qsize(input int w);
        case (w)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic logic [9:0] last_entry(input int w);
        if (qsize(w) == 0) return 'x;
        case (w)
            0:       return q0[q0.size()-1];
            1:       return q1[q1.size()-1];
            default: return q2[q2.size()-1];
        endcase
    endfunction

    // Reference: parity error when the number of ones in data+parity has the
    // wrong evenness; stop error when any transmitted stop bit is 0.
    function automatic logic [9:0] model(input logic [7:0] d, input logic p, input logic odd,
                                         input logic [1:0] stops, input int nstop);
        int   ones;
        logic perr;
        logic serr;
        ones = $countones(d) + int'(p);
        perr = ((ones % 2) == 1) != odd;
        serr = (stops[0] == 1'b0) || (nstop == 2 && stops[1] == 1'b0);
        return {serr, perr, d};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input int w, input logic b);
        rx_line[w] = b;
        cycles(CPB);
    endtask

    task automatic send_frame(input int w, input logic [7:0] d, input logic p,
                              input logic [1:0] stops, input int nstop);
        send_bit(w, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(w, d[i]);
        send_bit(w, p);
        send_bit(w, stops[0]);
        if (nstop == 2) send_bit(w, stops[1]);
        rx_line[w] = 1'b1;
    endtask

    task automatic wait_frames(input int w, input int n);
        int c;
        c = 0;
        while (qsize(w) < n && c < 200) begin
            cycles(1);
            c++;
        end
        check($sformatf("frame_count_dut%0d", w), qsize(w), n);
    endtask

    task automatic do_frame(input int w, input logic [7:0] d, input logic p,
                            input logic [1:0] stops, input int nstop, input logic odd);
        logic [9:0] exp;
        logic [9:0] got;
        send_frame(w, d, p, stops, nstop);
        exp_cnt[w]++;
        wait_frames(w, exp_cnt[w]);
        exp = model(d, p, odd, stops, nstop);
        got = last_entry(w);
        $display("dut%0d frame data=%02h p=%0b stops=%b -> data=%02h perr=%0b serr=%0b",
                 w, d, p, stops, got[7:0], got[8], got[9]);
        check($sformatf("frame_word_dut%0d", w), got, exp);
        cycles(CPB);
    endtask

    initial begin
        logic [7:0] rd;
        logic       rp;
        logic       rs;
        int         pbefore;

        rst = 1'b1;
        ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rx_line[i] = 1'b1;
            exp_cnt[i] = 0;
        end
        cycles(3);
        check("reset_valid", valid_o[0], 1'b0);
        check("reset_data",  data_o[0], 8'h00);
        check("reset_flags", {perr_o[0], serr_o[0], ovr_o[0]}, 3'b000);
        check("reset_busy",  busy_o[0], 1'b0);
        rst = 1'b0;
        cycles(2 * CPB);

        // Clean frame, single valid pulse
        pbefore = pulses0;
        do_frame(0, 8'hA5, 1'b0, 2'b11, 1, 1'b0);
        check("a5_one_pulse", pulses0 - pbefore, 1);

        // Parity: even instance flags, odd instance accepts
        do_frame(0, 8'h3C, 1'b1, 2'b11, 1, 1'b0);
        do_frame(1, 8'h3C, 1'b1, 2'b11, 1, 1'b1);

        // Stop-bit error, then clean recovery
        do_frame(0, 8'h55, 1'b0, 2'b10, 1, 1'b0);
        do_frame(0, 8'h0F, 1'b0, 2'b11, 1, 1'b0);

        // Short glitch is rejected at mid-start
        rx_line[0] = 1'b0;
        cycles(4);
        check("glitch_busy_high", busy_o[0], 1'b1);
        cycles(1);
        rx_line[0] = 1'b1;
        cycles(8);
        check("glitch_busy_low", busy_o[0], 1'b0);
        cycles(CPB);
        check("glitch_no_frame", qsize(0), exp_cnt[0]);

        // Overrun: second frame dropped while the first is held
        ready = 1'b0;
        send_frame(0, 8'h11, 1'b0, 2'b11, 1);
        cycles(CPB);
        check("ovr_first_valid", valid_o[0], 1'b1);
        check("ovr_first_data", data_o[0], 8'h11);
        send_frame(0, 8'h22, 1'b0, 2'b11, 1);
        cycles(CPB);
        check("ovr_held_data", data_o[0], 8'h11);
        check("ovr_flag", ovr_o[0], 1'b1);
        ready = 1'b1;
        cycles(1);
        check("ovr_cleared_valid", valid_o[0], 1'b0);
        check("ovr_cleared_flag", ovr_o[0], 1'b0);
        exp_cnt[0]++;
        check("ovr_delivered", last_entry(0), model(8'h11, 1'b0, 1'b0, 2'b11, 1));
        cycles(CPB);

        // Reset mid-frame aborts with no output
        send_bit(0, 1'b0);
        send_bit(0, 1'b1);
        send_bit(0, 1'b0);
        send_bit(0, 1'b0);
        rx_line[0] = 1'b1;
        rst = 1'b1;
        cycles(2);
        rst = 1'b0;
        cycles(1);
        check("rst_abort_busy", busy_o[0], 1'b0);
        check("rst_abort_valid", valid_o[0], 1'b0);
        cycles(2 * CPB);
        do_frame(0, 8'h42, 1'b0, 2'b11, 1, 1'b0);

        // Break: line low across a whole frame
        rx_line[0] = 1'b0;
        cycles(14 * CPB);
        exp_cnt[0]++;
        wait_frames(0, exp_cnt[0]);
        check("break_word", last_entry(0), {1'b1, 1'b0, 8'h00});
        cycles(4 * CPB);
        check("break_no_restart", qsize(0), exp_cnt[0]);
        rx_line[0] = 1'b1;
        cycles(2 * CPB);
        do_frame(0, 8'hC3, 1'b0, 2'b11, 1, 1'b0);

        // Two stop bits: both checked
        do_frame(2, 8'h5A, 1'b0, 2'b11, 2, 1'b0);
        do_frame(2, 8'h5A, 1'b0, 2'b01, 2, 1'b0);

        // Randomized frames against the reference
        for (int k = 0; k < 8; k++) begin
            rd = 8'($urandom);
            rp = 1'($urandom);
            rs = ($urandom_range(0, 3) != 0);
            do_frame(0, rd, rp, {1'b1, rs}, 1, 1'b0);
        end
        for (int k = 0; k < 3; k++) begin
            rd = 8'($urandom);
            rp = 1'($urandom);
            do_frame(1, rd, rp, 2'b11, 1, 1'b1);
        end
        for (int k = 0; k < 3; k++) begin
            rd = 8'($urandom);
            rp = 1'($urandom);
            do_frame(2, rd, rp, 2'($urandom), 2, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
